// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: 640x480@60 timing defaults, derived raster bounds and counter types
package vga_timing_gen_pkg;
   localparam int CNT_W = 10;
   localparam int MAX_TOTAL = 1 << CNT_W;
   localparam int DEF_CLK_DIV = 4;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP = 48;
   localparam int DEF_H_VIS = 640;
   localparam int DEF_H_FP = 16;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP = 33;
   localparam int DEF_V_VIS = 480;
   localparam int DEF_V_FP = 10;
   localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_VIS + DEF_H_FP;
   localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_VIS + DEF_V_FP;
   localparam int DEF_H_VIS_START = DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_VIS_START = DEF_V_SYNC + DEF_V_BP;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [11:0] rgb_t;
   // unsigned window test [lo, lo+n); done in int so an end bound of 1024 cannot alias to 0
   function automatic logic in_span(cnt_t c, int lo, int n);
      return int'(c) >= lo && int'(c) < lo + n;
   endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster bus from the timing generator to the game logic and monitor pins,
// plus the colour return path from the game logic
interface vga_timing_if;
   import vga_timing_gen_pkg::*;
   cnt_t hCount;
   cnt_t vCount;
   logic bright;
   logic pix_en;
   logic line_tick;
   logic frame_tick;
   logic hSync;
   logic vSync;
   logic [3:0] vgaR;
   logic [3:0] vgaG;
   logic [3:0] vgaB;
   rgb_t rgb_in;
   modport master (output hCount, vCount, bright, pix_en, line_tick, frame_tick, hSync, vSync, vgaR, vgaG, vgaB,
                   input rgb_in);
   modport slave (input hCount, vCount, bright, pix_en, line_tick, frame_tick, hSync, vSync, vgaR, vgaG, vgaB,
                  output rgb_in);
endinterface

// File: rtl/vga_timing_gen_pix_en_gen.sv
// pix_en_gen: modulo-CLK_DIV divider; pix_en_o is high on the last count of each cycle
module pix_en_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic pix_en_o
);
   localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
   logic [W-1:0] div_q, div_d;
   if (CLK_DIV < 1) begin : g_bad_div
      $error("pix_en_gen: CLK_DIV must be at least 1");
   end
   assign pix_en_o = div_q == LAST;
   always_comb div_d = pix_en_o ? '0 : div_q + 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) div_q <= '0;
      else     div_q <= div_d;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, visible-window decode and one-pixel-latency sync/RGB pin registers.
// Sync pulses start at count 0, so the visible window follows sync plus back porch.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int H_VIS   = DEF_H_VIS,
   parameter int H_FP    = DEF_H_FP,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP,
   parameter int V_VIS   = DEF_V_VIS,
   parameter int V_FP    = DEF_V_FP
) (
   input logic         clk,
   input logic         rst,
   vga_timing_if.master vga
);
   localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
   localparam int H_VIS_START = H_SYNC + H_BP;
   localparam int V_VIS_START = V_SYNC + V_BP;
   localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counters");
   end
   logic pix_en, h_wrap, v_wrap, bright;
   cnt_t h_count_q, h_count_d, v_count_q, v_count_d;
   logic hsync_q, hsync_d, vsync_q, vsync_d;
   logic line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;
   rgb_t rgb_q, rgb_d;
   pix_en_gen #(.CLK_DIV(CLK_DIV)) u_pix_en (
      .clk      (clk),
      .rst      (rst),
      .pix_en_o (pix_en)
   );
   // pins are sampled from the current counters, so they trail the bus by one pixel but stay mutually aligned
   always_comb begin
      h_wrap       = h_count_q == H_LAST;
      v_wrap       = v_count_q == V_LAST;
      bright       = in_span(h_count_q, H_VIS_START, H_VIS) && in_span(v_count_q, V_VIS_START, V_VIS);
      h_count_d    = pix_en ? (h_wrap ? '0 : h_count_q + 1'b1) : h_count_q;
      v_count_d    = (pix_en && h_wrap) ? (v_wrap ? '0 : v_count_q + 1'b1) : v_count_q;
      line_tick_d  = pix_en && h_wrap;
      frame_tick_d = pix_en && h_wrap && v_wrap;
      hsync_d      = pix_en ? !in_span(h_count_q, 0, H_SYNC) : hsync_q;
      vsync_d      = pix_en ? !in_span(v_count_q, 0, V_SYNC) : vsync_q;
      rgb_d        = pix_en ? (bright ? vga.rgb_in : '0) : rgb_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         h_count_q    <= '0;
         v_count_q    <= '0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         line_tick_q  <= 1'b0;
         frame_tick_q <= 1'b0;
         rgb_q        <= '0;
      end else begin
         h_count_q    <= h_count_d;
         v_count_q    <= v_count_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         line_tick_q  <= line_tick_d;
         frame_tick_q <= frame_tick_d;
         rgb_q        <= rgb_d;
      end
   assign vga.hCount     = h_count_q;
   assign vga.vCount     = v_count_q;
   assign vga.bright     = bright;
   assign vga.pix_en     = pix_en;
   assign vga.line_tick  = line_tick_q;
   assign vga.frame_tick = frame_tick_q;
   assign vga.hSync      = hsync_q;
   assign vga.vSync      = vsync_q;
   assign {vga.vgaR, vga.vgaG, vga.vgaB} = rgb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on full 640x480 timing (CLK_DIV 4 and 1) and on a
// reduced 19x10 raster (CLK_DIV 4 and 1) so whole frames fit in a short run.
module tb_vga_timing_gen;
   logic clk, rst;
   int total, bad, ncyc;
   vga_timing_if if_a ();
   vga_timing_if if_b ();
   vga_timing_if if_c ();
   vga_timing_if if_d ();
   vga_timing_gen dut_a (.clk(clk), .rst(rst), .vga(if_a));
   vga_timing_gen #(.CLK_DIV(1)) dut_b (.clk(clk), .rst(rst), .vga(if_b));
   // reduced raster: H 4+3+10+2=19, V 2+2+5+1=10, visible h 7..16, v 4..8
   vga_timing_gen #(.CLK_DIV(4), .H_SYNC(4), .H_BP(3), .H_VIS(10), .H_FP(2),
                    .V_SYNC(2), .V_BP(2), .V_VIS(5), .V_FP(1)) dut_c (.clk(clk), .rst(rst), .vga(if_c));
   vga_timing_gen #(.CLK_DIV(1), .H_SYNC(4), .H_BP(3), .H_VIS(10), .H_FP(2),
                    .V_SYNC(2), .V_BP(2), .V_VIS(5), .V_FP(1)) dut_d (.clk(clk), .rst(rst), .vga(if_d));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk or posedge rst)
      if (rst) ncyc <= 0;
      else     ncyc <= ncyc + 1;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_until(int t);
      while (ncyc < t) step();
   endtask
   function automatic int next_base(int per);
      return (ncyc / per + 1) * per;
   endfunction
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      total++;
      if (if_a.hCount !== 10'd0 || if_a.vCount !== 10'd0 || if_a.hSync !== 1'b1 || if_a.vSync !== 1'b1 ||
          {if_a.vgaR, if_a.vgaG, if_a.vgaB} !== 12'h000 || if_a.line_tick !== 1'b0 || if_a.frame_tick !== 1'b0 ||
          if_a.pix_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_values: got h=%0d v=%0d hs=%b vs=%b rgb=%h lt=%b ft=%b pe=%b want 0 0 1 1 000 0 0 0",
                  if_a.hCount, if_a.vCount, if_a.hSync, if_a.vSync, {if_a.vgaR, if_a.vgaG, if_a.vgaB},
                  if_a.line_tick, if_a.frame_tick, if_a.pix_en);
      end
      @(negedge clk) rst = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         total++;
         if (if_a.pix_en !== (e == 3) || if_a.hCount !== ((e == 4) ? 10'd1 : 10'd0)) begin
            bad++;
            $display("FAIL first_pix_en edge%0d: got pe=%b h=%0d want pe=%b h=%0d",
                     e, if_a.pix_en, if_a.hCount, e == 3, (e == 4) ? 1 : 0);
         end
      end
      wait_until(1200);
      total++;
      if (if_a.hCount !== 10'd300) begin
         bad++;
         $display("FAIL pre_reset_h: got %0d want 300", if_a.hCount);
      end
      total++;
      if (if_c.vgaR !== 4'hF) begin
         bad++;
         $display("FAIL pre_reset_rgb: got %h want f", if_c.vgaR);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (if_a.hCount !== 10'd0 || if_a.vCount !== 10'd0 || if_a.pix_en !== 1'b0 || if_c.hCount !== 10'd0 ||
          if_c.vCount !== 10'd0 || if_c.vgaR !== 4'h0 || if_c.hSync !== 1'b1 || if_c.vSync !== 1'b1) begin
         bad++;
         $display("FAIL async_reset: got a(h=%0d v=%0d pe=%b) c(h=%0d v=%0d r=%h hs=%b vs=%b) want zeros, syncs 1",
                  if_a.hCount, if_a.vCount, if_a.pix_en, if_c.hCount, if_c.vCount, if_c.vgaR, if_c.hSync, if_c.vSync);
      end
      step();
      total++;
      if (if_a.hCount !== 10'd0 || if_a.hSync !== 1'b1 || if_a.vSync !== 1'b1) begin
         bad++;
         $display("FAIL reset_hold: got h=%0d hs=%b vs=%b want 0 1 1", if_a.hCount, if_a.hSync, if_a.vSync);
      end
      @(negedge clk) rst = 1'b0;
   endtask
   task automatic test_hsync_width();
      int n;
      n = 0;
      while (if_a.hSync !== 1'b0 && n < 100) begin
         step();
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("FAIL hsync_start: got no low within %0d clk want low by clk 4", n);
      end
      n = 0;
      while (if_a.hSync === 1'b0 && n < 5000) begin
         step();
         n++;
      end
      total++;
      if (n != 384) begin
         bad++;
         $display("FAIL hsync_low_width: got %0d want 384", n);
      end
      n = 0;
      while (if_a.hSync === 1'b1 && n < 5000) begin
         step();
         n++;
      end
      total++;
      if (n != 2816) begin
         bad++;
         $display("FAIL hsync_high_width: got %0d want 2816", n);
      end
   endtask
   task automatic test_vis_edges();
      int ph[4] = '{144, 143, 144, 784};
      int pv[4] = '{34, 35, 35, 35};
      logic pb[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         wait_until(pv[i] * 800 + ph[i]);
         total++;
         if (if_b.hCount !== 10'(ph[i]) || if_b.vCount !== 10'(pv[i]) || if_b.bright !== pb[i]) begin
            bad++;
            $display("FAIL vis_edge%0d: got (%0d,%0d) bright=%b want (%0d,%0d) bright=%b",
                     i, if_b.hCount, if_b.vCount, if_b.bright, ph[i], pv[i], pb[i]);
         end
         step();
         total++;
         if (if_b.vgaR !== (pb[i] ? 4'hF : 4'h0) || if_b.vgaG !== 4'h0 || if_b.vgaB !== 4'h0) begin
            bad++;
            $display("FAIL vis_rgb%0d: got %h%h%h want %h00", i, if_b.vgaR, if_b.vgaG, if_b.vgaB, pb[i] ? 4'hF : 4'h0);
         end
      end
      wait_until(35 * 800 + 799);
      total++;
      if (if_b.hCount !== 10'd799 || if_b.vCount !== 10'd35 || if_b.line_tick !== 1'b0) begin
         bad++;
         $display("FAIL pre_line_wrap: got (%0d,%0d) lt=%b want (799,35) lt=0", if_b.hCount, if_b.vCount, if_b.line_tick);
      end
      step();
      total++;
      if (if_b.hCount !== 10'd0 || if_b.vCount !== 10'd36 || if_b.line_tick !== 1'b1 || if_b.frame_tick !== 1'b0) begin
         bad++;
         $display("FAIL line_wrap: got (%0d,%0d) lt=%b ft=%b want (0,36) lt=1 ft=0",
                  if_b.hCount, if_b.vCount, if_b.line_tick, if_b.frame_tick);
      end
   endtask
   task automatic test_small_corners();
      int ch[6] = '{7, 6, 7, 16, 17, 16};
      int cv[6] = '{3, 4, 4, 8, 8, 9};
      logic cb[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic pb[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int base, k;
      base = next_base(760);
      for (int i = 0; i < 6; i++) begin
         k = base + 4 * (cv[i] * 19 + ch[i]);
         wait_until(k);
         total++;
         if (if_c.hCount !== 10'(ch[i]) || if_c.vCount !== 10'(cv[i]) || if_c.bright !== cb[i]) begin
            bad++;
            $display("FAIL corner%0d: got (%0d,%0d) bright=%b want (%0d,%0d) bright=%b",
                     i, if_c.hCount, if_c.vCount, if_c.bright, ch[i], cv[i], cb[i]);
         end
         wait_until(k + 3);
         total++;
         if (if_c.vgaR !== (pb[i] ? 4'hF : 4'h0)) begin
            bad++;
            $display("FAIL corner_hold%0d: got %h want %h", i, if_c.vgaR, pb[i] ? 4'hF : 4'h0);
         end
         wait_until(k + 4);
         total++;
         if (if_c.vgaR !== (cb[i] ? 4'hF : 4'h0)) begin
            bad++;
            $display("FAIL corner_rgb%0d: got %h want %h", i, if_c.vgaR, cb[i] ? 4'hF : 4'h0);
         end
      end
   endtask
   task automatic test_frame_wrap();
      int base;
      base = next_base(760);
      wait_until(base - 1);
      total++;
      if (if_c.hCount !== 10'd18 || if_c.vCount !== 10'd9 || if_c.pix_en !== 1'b1 || if_c.line_tick !== 1'b0) begin
         bad++;
         $display("FAIL pre_frame_wrap: got (%0d,%0d) pe=%b lt=%b want (18,9) pe=1 lt=0",
                  if_c.hCount, if_c.vCount, if_c.pix_en, if_c.line_tick);
      end
      step();
      total++;
      if (if_c.hCount !== 10'd0 || if_c.vCount !== 10'd0 || if_c.line_tick !== 1'b1 || if_c.frame_tick !== 1'b1) begin
         bad++;
         $display("FAIL frame_wrap: got (%0d,%0d) lt=%b ft=%b want (0,0) lt=1 ft=1",
                  if_c.hCount, if_c.vCount, if_c.line_tick, if_c.frame_tick);
      end
      step();
      total++;
      if (if_c.line_tick !== 1'b0 || if_c.frame_tick !== 1'b0) begin
         bad++;
         $display("FAIL tick_width: got lt=%b ft=%b want 0 0", if_c.line_tick, if_c.frame_tick);
      end
      wait_until(base + 4 * 76);
      total++;
      if (if_c.hCount !== 10'd0 || if_c.vCount !== 10'd4 || if_c.line_tick !== 1'b1 || if_c.frame_tick !== 1'b0) begin
         bad++;
         $display("FAIL small_line_wrap: got (%0d,%0d) lt=%b ft=%b want (0,4) lt=1 ft=0",
                  if_c.hCount, if_c.vCount, if_c.line_tick, if_c.frame_tick);
      end
   endtask
   task automatic test_frame_period();
      int n, lines;
      n = 0;
      while (if_c.frame_tick !== 1'b1 && n < 1000) begin
         step();
         n++;
      end
      n = 0;
      lines = 0;
      do begin
         if (if_c.line_tick === 1'b1) lines++;
         step();
         n++;
      end while (if_c.frame_tick !== 1'b1 && n < 2000);
      total++;
      if (n != 760) begin
         bad++;
         $display("FAIL frame_period: got %0d want 760", n);
      end
      total++;
      if (lines != 10) begin
         bad++;
         $display("FAIL lines_per_frame: got %0d want 10", lines);
      end
   endtask
   task automatic test_vsync_width();
      int n;
      n = 0;
      while (if_c.vSync !== 1'b0 && n < 1000) begin
         step();
         n++;
      end
      n = 0;
      while (if_c.vSync === 1'b0 && n < 2000) begin
         step();
         n++;
      end
      total++;
      if (n != 152) begin
         bad++;
         $display("FAIL vsync_low_width: got %0d want 152", n);
      end
      n = 0;
      while (if_c.vSync === 1'b1 && n < 2000) begin
         step();
         n++;
      end
      total++;
      if (n != 608) begin
         bad++;
         $display("FAIL vsync_high_width: got %0d want 608", n);
      end
   endtask
   task automatic test_clk_div1();
      int n, base;
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (if_d.pix_en !== 1'b1) begin
            bad++;
            $display("FAIL div1_pix_en%0d: got %b want 1", i, if_d.pix_en);
         end
      end
      n = 0;
      while (if_d.frame_tick !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      n = 0;
      do begin
         step();
         n++;
      end while (if_d.frame_tick !== 1'b1 && n < 400);
      total++;
      if (n != 190) begin
         bad++;
         $display("FAIL div1_frame_period: got %0d want 190", n);
      end
      base = next_base(190);
      wait_until(base);
      total++;
      if (if_d.hSync !== 1'b1) begin
         bad++;
         $display("FAIL div1_hsync_pre: got %b want 1", if_d.hSync);
      end
      step();
      total++;
      if (if_d.hSync !== 1'b0 || if_d.vSync !== 1'b0) begin
         bad++;
         $display("FAIL div1_sync_align: got hs=%b vs=%b want 0 0", if_d.hSync, if_d.vSync);
      end
      wait_until(base + 83);
      total++;
      if (if_d.vgaR !== 4'h0) begin
         bad++;
         $display("FAIL div1_rgb_pre: got %h want 0", if_d.vgaR);
      end
      step();
      total++;
      if (if_d.vgaR !== 4'hF) begin
         bad++;
         $display("FAIL div1_rgb_in: got %h want f", if_d.vgaR);
      end
   endtask
   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      if_a.rgb_in = 12'hF00;
      if_b.rgb_in = 12'hF00;
      if_c.rgb_in = 12'hF00;
      if_d.rgb_in = 12'hF00;
      test_reset();
      test_hsync_width();
      test_vis_edges();
      test_small_corners();
      test_frame_wrap();
      test_frame_period();
      test_vsync_width();
      test_clk_div1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
